avl_ddr3_responder: RTL and testbench

Avalon-MM slave that stands in for the DDR3 controller, answering the single-beat read/write traffic the write-back accumulator issues on the `avl_*` interface. It provides on-chip 128-bit storage with programmable wait-request stalls and a fixed read latency. The accumulator and the bring-up benches connect to it in place of the UniPHY controller, so DDR3 load/store sequences run without external memory.

---
 rtl/avl_ddr3_responder.sv | 152 +++++++++++++++
 tb/tb_avl_ddr3_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_ddr3_responder.sv
// On-chip stand-in for the DDR3 controller's Avalon-MM port. It serves single-beat reads and
// writes with a programmable wait-request stall and a fixed read latency.
module avl_ddr3_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 448,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 4
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  avl_burstbegin,
    input  logic [ADDR_WIDTH-1:0] avl_address,
    input  logic                  avl_read,
    input  logic                  avl_write,
    input  logic [DATA_WIDTH-1:0] avl_writedata,
    output logic                  avl_wait_request_n,
    output logic [DATA_WIDTH-1:0] avl_readdata,
    output logic                  avl_readdatavalid,
    output logic                  oERR,
    output logic [15:0]           oRD_COUNT,
    output logic [15:0]           oWR_COUNT
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STALL,
        ST_ACK
    } state_t;

    state_t                r_state;
    logic [3:0]            r_stall_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_data [READ_LATENCY];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_do_write;
    logic                  w_push;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_req      = avl_read | avl_write;
    assign w_accept   = (r_state == ST_ACK);
    assign w_in_range = (avl_address < ADDR_WIDTH'(DEPTH));
    assign w_idx      = avl_address[IDX_W-1:0];
    // Reset wins over a write that lands on the same edge as the acknowledge.
    assign w_do_write = w_accept & avl_write & w_in_range & ~iRST;
    // A simultaneous read and write keeps only the write.
    assign w_push     = w_accept & avl_read & ~avl_write;
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    // NOTE: the storage array is deliberately left out of reset, so it maps onto RAM and its
    // contents survive iRST.
    always_ff @(posedge iCLK) begin
        if (w_do_write) begin
            r_mem[w_idx] <= avl_writedata;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state            <= ST_IDLE;
            r_stall_cnt        <= '0;
            avl_wait_request_n <= 1'b0;
            oERR               <= 1'b0;
            oRD_COUNT          <= '0;
            oWR_COUNT          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    avl_wait_request_n <= 1'b0;
                    if (w_req) begin
                        if (!avl_burstbegin) begin
                            oERR <= 1'b1;
                        end
                        if (WAIT_CYCLES == 0) begin
                            r_state            <= ST_ACK;
                            avl_wait_request_n <= 1'b1;
                        end else begin
                            r_state     <= ST_STALL;
                            r_stall_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                ST_STALL: begin
                    r_stall_cnt <= r_stall_cnt - 4'd1;
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                        oERR    <= 1'b1;
                    end else if (r_stall_cnt == 4'd1) begin
                        r_state            <= ST_ACK;
                        avl_wait_request_n <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state            <= ST_IDLE;
                    avl_wait_request_n <= 1'b0;
                    if (!w_req || (avl_read && avl_write)) begin
                        oERR <= 1'b1;
                    end
                    if (avl_write) begin
                        if (oWR_COUNT != 16'hFFFF) begin
                            oWR_COUNT <= oWR_COUNT + 16'd1;
                        end
                        if (!w_in_range) begin
                            oERR <= 1'b1;
                        end
                    end
                    if (w_push) begin
                        if (oRD_COUNT != 16'hFFFF) begin
                            oRD_COUNT <= oRD_COUNT + 16'd1;
                        end
                        if (!w_in_range) begin
                            oERR <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Data advances only behind a valid bit, so the last stage holds the most recent response.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe_data[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_push;
            if (w_push) begin
                r_pipe_data[0] <= w_rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                if (r_pipe_vld[k-1]) begin
                    r_pipe_data[k] <= r_pipe_data[k-1];
                end
            end
        end
    end

    assign avl_readdatavalid = r_pipe_vld[READ_LATENCY-1];
    assign avl_readdata      = r_pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_avl_ddr3_responder.sv
// Bench for avl_ddr3_responder: default instance (2 waits, latency 4) plus a zero-wait,
// latency-1 instance, compared against a transaction-level memory and response model.
module tb_avl_ddr3_responder;

    localparam int AW    = 26;
    localparam int DW    = 128;
    localparam int DEPTH = 448;
    localparam int W_A   = 2;
    localparam int L_A   = 4;
    localparam int W_B   = 0;
    localparam int L_B   = 1;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_bb = 1'b0, a_rd = 1'b0, a_wr = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_wrn, a_rdv, a_err;
    logic [DW-1:0] a_rdata;
    logic [15:0]   a_rdc, a_wrc;

    logic          b_bb = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_wrn, b_rdv, b_err;
    logic [DW-1:0] b_rdata;
    logic [15:0]   b_rdc, b_wrc;

    avl_ddr3_responder #(.WAIT_CYCLES(W_A), .READ_LATENCY(L_A)) dut_a (
        .iCLK(clk), .iRST(rst), .avl_burstbegin(a_bb), .avl_address(a_addr),
        .avl_read(a_rd), .avl_write(a_wr), .avl_writedata(a_wdata),
        .avl_wait_request_n(a_wrn), .avl_readdata(a_rdata), .avl_readdatavalid(a_rdv),
        .oERR(a_err), .oRD_COUNT(a_rdc), .oWR_COUNT(a_wrc)
    );

    avl_ddr3_responder #(.WAIT_CYCLES(W_B), .READ_LATENCY(L_B)) dut_b (
        .iCLK(clk), .iRST(rst), .avl_burstbegin(b_bb), .avl_address(b_addr),
        .avl_read(b_rd), .avl_write(b_wr), .avl_writedata(b_wdata),
        .avl_wait_request_n(b_wrn), .avl_readdata(b_rdata), .avl_readdatavalid(b_rdv),
        .oERR(b_err), .oRD_COUNT(b_rdc), .oWR_COUNT(b_wrc)
    );

    int n_asserts  = 0;
    int n_fails    = 0;
    int edge_count = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [DW-1:0] m_mem [2][DEPTH];
    int m_wr[2]      = '{0, 0};
    int m_rd[2]      = '{0, 0};
    bit m_err[2]     = '{1'b0, 1'b0};
    int n_strobes[2] = '{0, 0};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A strobe is expected exactly at the negedge of the cycle sampled at accept + latency.
    task automatic check_rdv(input bit b);
        logic v;
        logic [DW-1:0] d;
        bit is_due;
        exp_t e;
        v      = b ? b_rdv : a_rdv;
        d      = b ? b_rdata : a_rdata;
        is_due = 1'b0;
        e.due  = 0;
        e.data = '0;
        if (b) begin
            if (q_b.size() > 0 && q_b[0].due == edge_count) begin
                is_due = 1'b1;
                e = q_b.pop_front();
            end
        end else begin
            if (q_a.size() > 0 && q_a[0].due == edge_count) begin
                is_due = 1'b1;
                e = q_a.pop_front();
            end
        end
        chk(b ? "rdvalid_b" : "rdvalid_a", DW'(v), DW'(is_due));
        if (is_due) begin
            chk(b ? "rdata_b" : "rdata_a", d, e.data);
            if (v) n_strobes[b]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_count++;
        @(negedge clk);
        check_rdv(1'b0);
        check_rdv(1'b1);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input bit b, input logic rd, input logic wr, input logic bb,
                         input int unsigned addr, input logic [DW-1:0] d);
        if (b) begin
            b_rd = rd; b_wr = wr; b_bb = bb; b_addr = AW'(addr); b_wdata = d;
        end else begin
            a_rd = rd; a_wr = wr; a_bb = bb; a_addr = AW'(addr); a_wdata = d;
        end
    endtask

    // Holds a request until acknowledged; the model applies the command at the accept edge.
    task automatic xact(input bit b, input logic rd, input logic wr, input logic bb,
                        input int unsigned addr, input logic [DW-1:0] d,
                        output int lows, output int acc);
        exp_t e;
        int lat;
        lat  = b ? L_B : L_A;
        lows = 0;
        acc  = -1;
        drive(b, rd, wr, bb, addr, d);
        for (int i = 0; i < 40; i++) begin
            if ((b ? b_wrn : a_wrn) === 1'b1) begin
                acc = edge_count + 1;
                break;
            end
            lows++;
            tick();
        end
        if (acc < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            if (!bb) m_err[b] = 1'b1;
            if (wr) begin
                m_wr[b]++;
                if (addr < DEPTH) m_mem[b][addr] = d;
                else m_err[b] = 1'b1;
            end
            if (rd && !wr) begin
                m_rd[b]++;
                e.due  = acc + lat - 1;
                e.data = (addr < DEPTH) ? m_mem[b][addr] : '0;
                if (addr >= DEPTH) m_err[b] = 1'b1;
                if (b) q_b.push_back(e);
                else q_a.push_back(e);
            end
            if (rd && wr) m_err[b] = 1'b1;
        end
        tick();
        drive(b, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic do_wr(input bit b, input int unsigned addr, input logic [DW-1:0] d);
        int lw, ac;
        xact(b, 1'b0, 1'b1, 1'b1, addr, d, lw, ac);
    endtask

    task automatic do_rd(input bit b, input int unsigned addr);
        int lw, ac;
        xact(b, 1'b1, 1'b0, 1'b1, addr, '0, lw, ac);
    endtask

    task automatic flush_model();
        q_a.delete();
        q_b.delete();
        m_wr  = '{0, 0};
        m_rd  = '{0, 0};
        m_err = '{1'b0, 1'b0};
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush_model();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lows, acc, acc1, acc2, s0;
        int unsigned ra;
        logic [DW-1:0] d5, d30, d7, d8;

        // Reset state
        apply_reset();
        chk("rst_wrn", DW'(a_wrn), 0);
        chk("rst_rdv", DW'(a_rdv), 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_err", DW'(a_err), 0);
        chk("rst_rdc", DW'(a_rdc), 0);
        chk("rst_wrc", DW'(a_wrc), 0);
        chk("rst_rdata_b", b_rdata, 0);

        // Basic write/read with the handshake shape
        xact(1'b0, 1'b0, 1'b1, 1'b1, 5, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, lows, acc);
        chk("t1_wr_wait_low", DW'(lows), DW'(W_A + 1));
        s0 = n_strobes[0];
        xact(1'b0, 1'b1, 1'b0, 1'b1, 5, '0, lows, acc);
        chk("t1_rd_wait_low", DW'(lows), DW'(W_A + 1));
        wait_ticks(L_A + 2);
        chk("t1_strobes", DW'(n_strobes[0] - s0), 1);
        chk("t1_err", DW'(a_err), 0);

        // Full-buffer fill and readback
        apply_reset();
        s0 = n_strobes[0];
        for (int a = 0; a < DEPTH; a++) do_wr(1'b0, a, DW'(a));
        for (int a = 0; a < DEPTH; a++) do_rd(1'b0, a);
        wait_ticks(L_A + 2);
        chk("t2_strobes", DW'(n_strobes[0] - s0), 448);
        chk("t2_wrc", DW'(a_wrc), 448);
        chk("t2_rdc", DW'(a_rdc), 448);
        chk("t2_err", DW'(a_err), 0);

        // Out-of-range address
        do_wr(1'b0, DEPTH, '1);
        chk("t3_err", DW'(a_err), 1);
        s0 = n_strobes[0];
        do_rd(1'b0, 0);
        do_rd(1'b0, DEPTH);
        wait_ticks(L_A + 2);
        chk("t3_strobes", DW'(n_strobes[0] - s0), 2);

        // Simultaneous read and write
        s0 = n_strobes[0];
        xact(1'b0, 1'b1, 1'b1, 1'b1, 10, 128'hAA, lows, acc);
        wait_ticks(L_A + 2);
        chk("t4_no_strobe", DW'(n_strobes[0] - s0), 0);
        chk("t4_err", DW'(a_err), 1);
        chk("t4_wrc", DW'(a_wrc), DW'(m_wr[0]));
        do_rd(1'b0, 10);
        wait_ticks(L_A + 2);

        // Random traffic, including some out-of-range addresses
        for (int i = 0; i < 40; i++) begin
            ra = $urandom_range(0, DEPTH + 7);
            if ($urandom_range(0, 1) == 1) do_wr(1'b0, ra, {$urandom, $urandom, $urandom, $urandom});
            else do_rd(1'b0, ra);
        end
        wait_ticks(L_A + 2);
        chk("rand_wrc", DW'(a_wrc), DW'(m_wr[0]));
        chk("rand_err", DW'(a_err), DW'(m_err[0]));

        // Reset two edges after a read accept
        d5 = {$urandom, $urandom, $urandom, $urandom};
        do_wr(1'b0, 20, d5);
        s0 = n_strobes[0];
        xact(1'b0, 1'b1, 1'b0, 1'b1, 20, '0, lows, acc);
        tick();
        rst = 1'b1;
        flush_model();
        tick();
        rst = 1'b0;
        wait_ticks(L_A + 2);
        chk("t5_no_strobe", DW'(n_strobes[0] - s0), 0);
        chk("t5_rdc", DW'(a_rdc), 0);
        chk("t5_wrc", DW'(a_wrc), 0);
        chk("t5_err", DW'(a_err), 0);
        chk("t5_rdata", a_rdata, 0);
        s0 = n_strobes[0];
        do_rd(1'b0, 20);
        wait_ticks(L_A + 2);
        chk("t5_readback_strobes", DW'(n_strobes[0] - s0), 1);
        chk("t5_readback_err", DW'(a_err), 0);

        // Request withdrawn during the stall
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3, '0);
        tick();
        chk("drop_wrn", DW'(a_wrn), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        tick();
        m_err[0] = 1'b1;
        chk("drop_err", DW'(a_err), 1);
        wait_ticks(L_A + 2);
        chk("drop_rdc", DW'(a_rdc), DW'(m_rd[0]));

        // Request without burstbegin
        apply_reset();
        chk("bb_err_clear", DW'(a_err), 0);
        d30 = {$urandom, $urandom, $urandom, $urandom};
        xact(1'b0, 1'b0, 1'b1, 1'b0, 30, d30, lows, acc);
        chk("bb_err", DW'(a_err), 1);
        do_rd(1'b0, 30);
        wait_ticks(L_A + 2);
        chk("bb_wrc", DW'(a_wrc), 1);

        // Zero wait cycles, latency 1
        d7 = {$urandom, $urandom, $urandom, $urandom};
        d8 = {$urandom, $urandom, $urandom, $urandom};
        xact(1'b1, 1'b0, 1'b1, 1'b1, 7, d7, lows, acc);
        chk("t6_wait_low", DW'(lows), DW'(W_B + 1));
        do_wr(1'b1, 8, d8);
        s0 = n_strobes[1];
        xact(1'b1, 1'b1, 1'b0, 1'b1, 7, '0, lows, acc1);
        xact(1'b1, 1'b1, 1'b0, 1'b1, 8, '0, lows, acc2);
        chk("t6_accept_spacing", DW'(acc2 - acc1), 2);
        wait_ticks(L_B + 2);
        chk("t6_strobes", DW'(n_strobes[1] - s0), 2);
        chk("t6_rdc", DW'(b_rdc), 2);
        chk("t6_wrc", DW'(b_wrc), 2);
        chk("t6_err", DW'(b_err), 0);

        chk("pending_a", DW'(q_a.size()), 0);
        chk("pending_b", DW'(q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
